cp0_irq_controller: RTL and testbench

Parametrised coprocessor-0 with a multi-line vectored interrupt controller, the next generation of the single-line CP0. It holds EPC, Cause, Status, Mask, Mode and Pending registers behind the existing CP0 read/write port. It accepts `NUM_IRQ` interrupt lines, individually maskable and each either level- or edge-triggered, and prioritises them. It sits beside the CPU datapath: it supplies the take-interrupt decision and the cause index, and it captures the interrupted PC.

---
 rtl/cp0_irq_controller.sv | 133 +++++++++++++
 tb/tb_cp0_irq_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cp0_irq_controller.sv
// cp0_irq_controller: coprocessor-0 with NUM_IRQ maskable, prioritised
// interrupt lines, each individually level- or edge-triggered.
module cp0_irq_controller #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         c0_adr,
    input  logic [31:0]        c0_wdata,
    input  logic               c0_write,
    output logic [31:0]        c0_rdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [31:0]        epc_in,
    input  logic               eret,
    output logic               irq_take,
    output logic [31:0]        c0_state
);

    localparam logic [4:0] ADR_EPC    = 5'd0;
    localparam logic [4:0] ADR_CAUSE  = 5'd1;
    localparam logic [4:0] ADR_STATUS = 5'd2;
    localparam logic [4:0] ADR_MASK   = 5'd3;
    localparam logic [4:0] ADR_PEND   = 5'd4;
    localparam logic [4:0] ADR_MODE   = 5'd5;

    logic [31:0]        epc;
    logic [31:0]        cause;
    logic [31:0]        status;
    logic [31:0]        status_d;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] edge_pend;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] wr_bits;
    logic [4:0]         idx;
    logic [31:0]        rd_mux;

    logic wr_epc, wr_cause, wr_status, wr_mask, wr_pend, wr_mode;

    assign wr_epc    = c0_write && (c0_adr == ADR_EPC);
    assign wr_cause  = c0_write && (c0_adr == ADR_CAUSE);
    assign wr_status = c0_write && (c0_adr == ADR_STATUS);
    assign wr_mask   = c0_write && (c0_adr == ADR_MASK);
    assign wr_pend   = c0_write && (c0_adr == ADR_PEND);
    assign wr_mode   = c0_write && (c0_adr == ADR_MODE);

    assign wr_bits = c0_wdata[NUM_IRQ-1:0];

    // Edge lines report their latched bit, level lines the live input.
    assign pending  = (mode & edge_pend) | (~mode & irq_in);
    assign active   = pending & mask;
    assign irq_take = status[0] & ~status[1] & (|active);
    assign c0_state = status;

    // Lowest-numbered active line wins; scan from the top so it lands last.
    always_comb begin
        idx = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) idx = 5'(i);
        end
    end

    // Status: software write for storage bits, take/eret override EXL.
    always_comb begin
        status_d = status;
        if (wr_status) status_d = c0_wdata;
        if (irq_take) status_d[1] = 1'b1;
        else if (eret) status_d[1] = 1'b0;
    end

    // Register file for Status, EPC and Cause with take taking precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= 32'h1;
            epc    <= 32'h0;
            cause  <= 32'h0;
        end else begin
            status <= status_d;
            if (irq_take) begin
                epc   <= epc_in;
                cause <= {1'b1, 26'b0, idx};
            end else begin
                if (wr_epc)   epc   <= c0_wdata;
                if (wr_cause) cause <= c0_wdata;
            end
        end
    end

    // Mask and Mode only keep bits for implemented lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            mode <= '0;
        end else begin
            if (wr_mask) mask <= wr_bits;
            if (wr_mode) mode <= wr_bits;
        end
    end

    // Edge latch: a fresh edge beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev  <= '0;
            edge_pend <= '0;
        end else begin
            irq_prev <= irq_in;
            edge_pend <= (edge_pend & ~(wr_pend ? (wr_bits & mode) : '0))
                       | (irq_in & ~irq_prev & mode);
        end
    end

    // Read mux on pre-edge register values; unmapped addresses give 0.
    always_comb begin
        case (c0_adr)
            ADR_EPC:    rd_mux = epc;
            ADR_CAUSE:  rd_mux = cause;
            ADR_STATUS: rd_mux = status;
            ADR_MASK:   rd_mux = 32'(mask);
            ADR_PEND:   rd_mux = 32'(pending);
            ADR_MODE:   rd_mux = 32'(mode);
            default:    rd_mux = 32'h0;
        endcase
    end

    // Registered read port, sampled every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) c0_rdata <= 32'h0;
        else     c0_rdata <= rd_mux;
    end

endmodule

// File: tb/tb_cp0_irq_controller.sv
// tb_cp0_irq_controller: directed checks of the CP0 interrupt controller.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_cp0_irq_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  c0_adr;
    logic [31:0] c0_wdata;
    logic        c0_write;
    logic [31:0] c0_rdata;
    logic [7:0]  irq_in;
    logic [31:0] epc_in;
    logic        eret;
    logic        irq_take;
    logic [31:0] c0_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] d;
    logic [31:0] exp_rst [6];

    cp0_irq_controller #(.NUM_IRQ(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .c0_adr   (c0_adr),
        .c0_wdata (c0_wdata),
        .c0_write (c0_write),
        .c0_rdata (c0_rdata),
        .irq_in   (irq_in),
        .epc_in   (epc_in),
        .eret     (eret),
        .irq_take (irq_take),
        .c0_state (c0_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        c0_adr   = a;
        c0_wdata = v;
        c0_write = 1'b1;
        @(negedge clk);
        c0_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        c0_adr   = a;
        c0_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        v = c0_rdata;
    endtask

    initial begin
        rst = 1'b1;
        c0_adr = 5'd0;
        c0_wdata = 32'h0;
        c0_write = 1'b0;
        irq_in = 8'h0;
        epc_in = 32'h0;
        eret = 1'b0;
        exp_rst = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0};
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset: dirty some state, then reset mid-cycle.
        wr(5'd2, 32'hF0);
        wr(5'd3, 32'hFF);
        chk("status_pre_rst", c0_state, 32'hF0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("status_async_rst", c0_state, 32'h1);
        chk("take_rst", {31'b0, irq_take}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd(5'(i), d);
            chk($sformatf("rst_read_%0d", i), d, exp_rst[i]);
        end

        // Mask bits above NUM_IRQ read 0.
        wr(5'd3, 32'hFFFF_FFFF);
        rd(5'd3, d);
        chk("mask_width", d, 32'hFF);

        // Level take.
        wr(5'd3, 32'h0C);
        irq_in = 8'h0C;
        epc_in = 32'h400;
        #1 chk("level_take_hi", {31'b0, irq_take}, 32'h1);
        @(negedge clk);
        chk("level_take_lo", {31'b0, irq_take}, 32'h0);
        chk("level_status", c0_state, 32'h3);
        rd(5'd1, d);
        chk("level_cause", d, 32'h8000_0002);
        rd(5'd0, d);
        chk("level_epc", d, 32'h400);
        irq_in = 8'h00;
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
        chk("eret_status", c0_state, 32'h1);

        // Edge latch while in handler.
        wr(5'd5, 32'h01);
        wr(5'd3, 32'h01);
        wr(5'd2, 32'h3);
        irq_in = 8'h01;
        @(negedge clk);
        irq_in = 8'h00;
        chk("edge_no_take", {31'b0, irq_take}, 32'h0);
        rd(5'd4, d);
        chk("edge_pending", d, 32'h01);
        wr(5'd2, 32'h1);
        #1 chk("edge_take", {31'b0, irq_take}, 32'h1);
        @(negedge clk);
        chk("edge_status", c0_state, 32'h3);
        rd(5'd1, d);
        chk("edge_cause", d, 32'h8000_0000);

        // Write-1-to-clear against a simultaneous edge.
        wr(5'd4, 32'h01);
        rd(5'd4, d);
        chk("w1c_clear", d, 32'h0);
        irq_in = 8'h01;
        wr(5'd4, 32'h01);
        irq_in = 8'h00;
        rd(5'd4, d);
        chk("w1c_edge_wins", d, 32'h01);
        wr(5'd4, 32'h01);
        rd(5'd4, d);
        chk("w1c_clear2", d, 32'h0);

        // eret with a pending line, then take vs software Cause write.
        wr(5'd5, 32'h0);
        wr(5'd3, 32'h20);
        irq_in = 8'h20;
        epc_in = 32'h800;
        #1 chk("exl_blocks", {31'b0, irq_take}, 32'h0);
        @(negedge clk);
        eret = 1'b1;
        #1 chk("eret_cycle", {31'b0, irq_take}, 32'h0);
        @(negedge clk);
        eret = 1'b0;
        c0_adr = 5'd1;
        c0_wdata = 32'h55;
        c0_write = 1'b1;
        #1 chk("after_eret", {31'b0, irq_take}, 32'h1);
        @(negedge clk);
        c0_write = 1'b0;
        chk("sim_status", c0_state, 32'h3);
        rd(5'd1, d);
        chk("sim_cause", d, 32'h8000_0005);
        rd(5'd0, d);
        chk("sim_epc", d, 32'h800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
